btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer with per-entry 2-bit direction counters, the next-generation IF-stage predictor. Given the fetch PC, it returns a same-cycle hit, a taken/not-taken prediction and the predicted next PC. It is trained from the resolve stage with the branch outcome. A multi-cycle flush sequencer invalidates the table one set per cycle, for use on fence.i or context change.

---
 rtl/btb_assoc.sv | 191 +++++++++++++++++++
 tb/tb_btb_assoc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// btb_assoc : set-associative BTB with 2-bit direction counters and a
//             one-set-per-cycle invalidate sweep.   Revision 1.0
// ============================================================================
module btb_assoc #(
   parameter int XLEN = 32,
   parameter int SETS = 16,
   parameter int WAYS = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_if,
   input  logic            lookup_enable,
   input  logic            update_enable,
   input  logic [XLEN-1:0] pc_update,
   input  logic [XLEN-1:0] target_update,
   input  logic            taken_update,
   input  logic            is_jump_update,
   input  logic            flush,
   output logic            hit_valid,
   output logic            predict_taken,
   output logic [XLEN-1:0] target_predict,
   output logic [XLEN-1:0] pc_hit,
   output logic            busy
);

   localparam int IDX  = $clog2(SETS);
   localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAGW = XLEN - IDX - 2;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

   state_t              r_state;
   logic [IDX-1:0]      r_cnt;
   logic [WAYS-1:0]     r_valid  [SETS];
   logic [WAYS-1:0]     r_jmp    [SETS];
   logic [WB-1:0]       r_rr     [SETS];
   logic [1:0]          r_ctr    [SETS][WAYS];
   logic [TAGW-1:0]     r_tag    [SETS][WAYS];
   logic [XLEN-1:0]     r_target [SETS][WAYS];

   logic                w_busy;
   logic [IDX-1:0]      w_lk_idx;
   logic [TAGW-1:0]     w_lk_tag;
   logic                w_lk_match;
   logic [WB-1:0]       w_lk_way;
   logic                w_lk_jmp;
   logic                w_lk_ctr1;

   logic [IDX-1:0]      w_up_idx;
   logic [TAGW-1:0]     w_up_tag;
   logic                w_up_match;
   logic [WB-1:0]       w_up_way;
   logic                w_free_found;
   logic [WB-1:0]       w_free_way;
   logic [WB-1:0]       w_vic_way;
   logic [WB-1:0]       w_rr_next;
   logic                w_up_en;
   logic                w_do_hit;
   logic                w_do_alloc;
   logic [1:0]          w_old_ctr;
   logic                w_jmp_new;
   logic [1:0]          w_ctr_new;
   logic                w_unused_lsb;

   assign w_busy       = (r_state == S_SWEEP);
   assign busy         = w_busy;
   assign w_unused_lsb = ^{pc_if[1:0], pc_update[1:0]};

   // ---------------------------------------------------------------- lookup
   assign w_lk_idx = pc_if[IDX+1:2];
   assign w_lk_tag = pc_if[XLEN-1:IDX+2];

   always_comb begin
      w_lk_match = 1'b0;
      w_lk_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
            w_lk_match = 1'b1;
            w_lk_way   = WB'(w);
         end
      end
   end

   assign w_lk_jmp       = r_jmp[w_lk_idx][w_lk_way];
   assign w_lk_ctr1      = r_ctr[w_lk_idx][w_lk_way][1];
   assign hit_valid      = lookup_enable && !w_busy && w_lk_match;
   assign predict_taken  = hit_valid && (w_lk_jmp || w_lk_ctr1);
   assign target_predict = predict_taken ? r_target[w_lk_idx][w_lk_way]
                                         : pc_if + XLEN'(4);
   assign pc_hit         = hit_valid ? pc_if : '0;

   // ---------------------------------------------------------------- update
   assign w_up_idx = pc_update[IDX+1:2];
   assign w_up_tag = pc_update[XLEN-1:IDX+2];

   always_comb begin
      w_up_match   = 1'b0;
      w_up_way     = '0;
      w_free_found = 1'b0;
      w_free_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
            w_up_match = 1'b1;
            w_up_way   = WB'(w);
         end
      end
      // Descending scan so the lowest-numbered invalid way is the one kept.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_up_idx][w]) begin
            w_free_found = 1'b1;
            w_free_way   = WB'(w);
         end
      end
   end

   assign w_rr_next  = (WAYS == 1) ? '0 : r_rr[w_up_idx] + WB'(1);
   assign w_vic_way  = w_free_found ? w_free_way : r_rr[w_up_idx];
   assign w_up_en    = update_enable && !w_busy && !flush;
   assign w_do_hit   = w_up_en && w_up_match;
   assign w_do_alloc = w_up_en && !w_up_match && (taken_update || is_jump_update);

   always_comb begin
      w_old_ctr = r_ctr[w_up_idx][w_up_way];
      w_jmp_new = r_jmp[w_up_idx][w_up_way] | is_jump_update;
      if (w_jmp_new)
         w_ctr_new = 2'd3;
      else if (taken_update)
         w_ctr_new = (w_old_ctr == 2'd3) ? 2'd3 : w_old_ctr + 2'd1;
      else
         w_ctr_new = (w_old_ctr == 2'd0) ? 2'd0 : w_old_ctr - 2'd1;
   end

   // ------------------------------------------------- control state + sweep
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_jmp[s]   <= '0;
            r_rr[s]    <= '0;
            for (int w = 0; w < WAYS; w++)
               r_ctr[s][w] <= 2'd0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (flush) begin
                  r_state <= S_SWEEP;
                  r_cnt   <= '0;
               end
            end
            S_SWEEP: begin
               r_valid[r_cnt] <= '0;
               r_rr[r_cnt]    <= '0;
               r_cnt          <= r_cnt + IDX'(1);
               if (r_cnt == IDX'(SETS - 1))
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_do_hit) begin
            r_ctr[w_up_idx][w_up_way] <= w_ctr_new;
            r_jmp[w_up_idx][w_up_way] <= w_jmp_new;
         end

         if (w_do_alloc) begin
            r_valid[w_up_idx][w_vic_way] <= 1'b1;
            r_jmp[w_up_idx][w_vic_way]   <= is_jump_update;
            r_ctr[w_up_idx][w_vic_way]   <= is_jump_update ? 2'd3 : 2'd2;
            if (!w_free_found)
               r_rr[w_up_idx] <= w_rr_next;
         end
      end
   end

   // Tags and targets are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_do_alloc) begin
         r_tag[w_up_idx][w_vic_way]    <= w_up_tag;
         r_target[w_up_idx][w_vic_way] <= target_update;
      end else if (w_do_hit && taken_update) begin
         r_target[w_up_idx][w_up_way]  <= target_update;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// tb_btb_assoc : directed self-checking bench for btb_assoc (SETS=16, WAYS=2).
//                Revision 1.0
// ============================================================================
module tb_btb_assoc;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_if = '0;
   logic        lookup_enable = 1'b0;
   logic        update_enable = 1'b0;
   logic [31:0] pc_update = '0;
   logic [31:0] target_update = '0;
   logic        taken_update = 1'b0;
   logic        is_jump_update = 1'b0;
   logic        flush = 1'b0;
   logic        hit_valid;
   logic        predict_taken;
   logic [31:0] target_predict;
   logic [31:0] pc_hit;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   btb_assoc #(.XLEN(32), .SETS(16), .WAYS(2)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .pc_if          (pc_if),
      .lookup_enable  (lookup_enable),
      .update_enable  (update_enable),
      .pc_update      (pc_update),
      .target_update  (target_update),
      .taken_update   (taken_update),
      .is_jump_update (is_jump_update),
      .flush          (flush),
      .hit_valid      (hit_valid),
      .predict_taken  (predict_taken),
      .target_predict (target_predict),
      .pc_hit         (pc_hit),
      .busy           (busy)
   );

   task automatic do_reset();
      reset = 1'b0; lookup_enable = 1'b0; update_enable = 1'b0; flush = 1'b0;
      pc_if = '0; pc_update = '0; target_update = '0;
      taken_update = 1'b0; is_jump_update = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic tk, input logic jp);
      @(negedge clk);
      pc_update = pc; target_update = tgt; taken_update = tk;
      is_jump_update = jp; update_enable = 1'b1;
      @(posedge clk);
      #1 update_enable = 1'b0;
   endtask

   task automatic look(input logic [31:0] pc);
      @(negedge clk);
      lookup_enable = 1'b1;
      pc_if = pc;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; lookup_enable = 1'b1; pc_if = 32'h100;
      #1;
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL rst_hit got %0b want 0", hit_valid); end
      n_checks++; if (predict_taken !== 1'b0) begin n_errors++; $display("FAIL rst_pt got %0b want 0", predict_taken); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got %0b want 0", busy); end
      n_checks++; if (pc_hit !== 32'h0) begin n_errors++; $display("FAIL rst_pc_hit got %h want 0", pc_hit); end
      n_checks++; if (target_predict !== 32'h104) begin n_errors++; $display("FAIL rst_tp got %h want 104", target_predict); end
   endtask

   task automatic test_cold_alloc();
      do_reset();
      look(32'h100);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL cold_hit got %0b want 0", hit_valid); end
      n_checks++; if (target_predict !== 32'h104) begin n_errors++; $display("FAIL cold_tp got %h want 104", target_predict); end
      // lookup and update to the same set in one cycle: old contents seen
      @(negedge clk);
      pc_update = 32'h100; target_update = 32'h200; taken_update = 1'b1;
      is_jump_update = 1'b0; update_enable = 1'b1; pc_if = 32'h100;
      #1;
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL nobypass_hit got %0b want 0", hit_valid); end
      @(posedge clk);
      #1 update_enable = 1'b0;
      look(32'h100);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL alloc_hit got %0b want 1", hit_valid); end
      n_checks++; if (predict_taken !== 1'b1) begin n_errors++; $display("FAIL alloc_pt got %0b want 1", predict_taken); end
      n_checks++; if (target_predict !== 32'h200) begin n_errors++; $display("FAIL alloc_tp got %h want 200", target_predict); end
      n_checks++; if (pc_hit !== 32'h100) begin n_errors++; $display("FAIL alloc_pc_hit got %h want 100", pc_hit); end
   endtask

   task automatic test_hysteresis();
      do_reset();
      upd(32'h100, 32'h200, 1'b1, 1'b0);
      upd(32'h100, 32'h999, 1'b0, 1'b0);
      look(32'h100);
      n_checks++; if (predict_taken !== 1'b0) begin n_errors++; $display("FAIL hyst_c1_pt got %0b want 0", predict_taken); end
      upd(32'h100, 32'h999, 1'b0, 1'b0);
      look(32'h100);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL hyst_c0_hit got %0b want 1", hit_valid); end
      n_checks++; if (predict_taken !== 1'b0) begin n_errors++; $display("FAIL hyst_c0_pt got %0b want 0", predict_taken); end
      n_checks++; if (target_predict !== 32'h104) begin n_errors++; $display("FAIL hyst_c0_tp got %h want 104", target_predict); end
      repeat (3) upd(32'h100, 32'h200, 1'b1, 1'b0);
      upd(32'h100, 32'h777, 1'b0, 1'b0);
      look(32'h100);
      n_checks++; if (predict_taken !== 1'b1) begin n_errors++; $display("FAIL hyst_sat_pt got %0b want 1", predict_taken); end
      n_checks++; if (target_predict !== 32'h200) begin n_errors++; $display("FAIL hyst_sat_tp got %h want 200", target_predict); end
   endtask

   task automatic test_jump();
      do_reset();
      upd(32'h40, 32'h800, 1'b0, 1'b1);
      repeat (3) upd(32'h40, 32'h123, 1'b0, 1'b0);
      look(32'h40);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL jmp_hit got %0b want 1", hit_valid); end
      n_checks++; if (predict_taken !== 1'b1) begin n_errors++; $display("FAIL jmp_pt got %0b want 1", predict_taken); end
      n_checks++; if (target_predict !== 32'h800) begin n_errors++; $display("FAIL jmp_tp got %h want 800", target_predict); end
   endtask

   task automatic test_replacement();
      do_reset();
      upd(32'h100, 32'h1100, 1'b1, 1'b0);
      upd(32'h140, 32'h1140, 1'b1, 1'b0);
      upd(32'h180, 32'h1180, 1'b1, 1'b0);
      look(32'h100);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL repl_100_hit got %0b want 0", hit_valid); end
      look(32'h140);
      n_checks++; if (target_predict !== 32'h1140) begin n_errors++; $display("FAIL repl_140_tp got %h want 1140", target_predict); end
      look(32'h180);
      n_checks++; if (target_predict !== 32'h1180) begin n_errors++; $display("FAIL repl_180_tp got %h want 1180", target_predict); end
      upd(32'h1C0, 32'h11C0, 1'b1, 1'b0);
      look(32'h140);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL repl_140_evict got %0b want 0", hit_valid); end
      look(32'h180);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL repl_180_keep got %0b want 1", hit_valid); end
      look(32'h1C0);
      n_checks++; if (target_predict !== 32'h11C0) begin n_errors++; $display("FAIL repl_1c0_tp got %h want 11c0", target_predict); end
      upd(32'h300, 32'h1300, 1'b0, 1'b0);
      look(32'h300);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL repl_300_hit got %0b want 0", hit_valid); end
      look(32'h180);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL repl_180_after300 got %0b want 1", hit_valid); end
   endtask

   task automatic test_flush();
      int busy_cycles;
      logic sweep_hit;
      do_reset();
      upd(32'h104, 32'h2104, 1'b1, 1'b0);
      upd(32'h108, 32'h2108, 1'b1, 1'b0);
      upd(32'h10C, 32'h210C, 1'b1, 1'b0);
      upd(32'h110, 32'h2110, 1'b1, 1'b0);
      look(32'h110);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL flush_pre_hit got %0b want 1", hit_valid); end
      // flush and update in the same cycle: the update must be dropped
      @(negedge clk);
      flush = 1'b1; update_enable = 1'b1; pc_update = 32'h120;
      target_update = 32'h2120; taken_update = 1'b1; is_jump_update = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0; update_enable = 1'b0;
      lookup_enable = 1'b1; pc_if = 32'h104;
      busy_cycles = 0;
      sweep_hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cycles++;
         if (k == 3) begin
            flush = 1'b1; update_enable = 1'b1; pc_update = 32'h124;
            target_update = 32'h2124; taken_update = 1'b1;
         end else if (k == 4) begin
            flush = 1'b0; update_enable = 1'b0;
         end
         #1;
         if (hit_valid !== 1'b0 || predict_taken !== 1'b0 || pc_hit !== 32'h0) sweep_hit = 1'b1;
      end
      flush = 1'b0; update_enable = 1'b0;
      n_checks++; if (busy_cycles != 16) begin n_errors++; $display("FAIL flush_busy_len got %0d want 16", busy_cycles); end
      n_checks++; if (sweep_hit !== 1'b0) begin n_errors++; $display("FAIL flush_sweep_hit got %0b want 0", sweep_hit); end
      look(32'h104);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_104 got %0b want 0", hit_valid); end
      look(32'h10C);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_10c got %0b want 0", hit_valid); end
      look(32'h120);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop_120 got %0b want 0", hit_valid); end
      look(32'h124);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop_124 got %0b want 0", hit_valid); end
   endtask

   task automatic test_reset_mid_sweep();
      do_reset();
      upd(32'h100, 32'h3100, 1'b1, 1'b0);
      upd(32'h120, 32'h3120, 1'b1, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_busy_before got %0b want 1", busy); end
      reset = 1'b0; lookup_enable = 1'b1; pc_if = 32'h120;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy_reset got %0b want 0", busy); end
      n_checks++; if (target_predict !== 32'h124) begin n_errors++; $display("FAIL mid_tp_reset got %h want 124", target_predict); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy_release got %0b want 0", busy); end
      look(32'h120);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL mid_120_hit got %0b want 0", hit_valid); end
      look(32'h100);
      n_checks++; if (hit_valid !== 1'b0) begin n_errors++; $display("FAIL mid_100_hit got %0b want 0", hit_valid); end
      upd(32'h180, 32'h5180, 1'b1, 1'b0);
      look(32'h180);
      n_checks++; if (hit_valid !== 1'b1) begin n_errors++; $display("FAIL mid_realloc_hit got %0b want 1", hit_valid); end
      n_checks++; if (target_predict !== 32'h5180) begin n_errors++; $display("FAIL mid_realloc_tp got %h want 5180", target_predict); end
   endtask

   initial begin
      test_reset();
      test_cold_alloc();
      test_hysteresis();
      test_jump();
      test_replacement();
      test_flush();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
